// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program memory controller: controller states
// and the default instruction-word / address geometry.
package prog_mem_pkg;

    localparam int DATA_W_DEF = 67;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } pm_state_e;

endpackage

// File: rtl/pm_ram_1r1w.sv
// Simple dual-port synchronous RAM: one write port, one read port with a
// registered, enable-gated output. Contents and output register are not reset.
module pm_ram_1r1w #(
    parameter int DATA_W = 67,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: output only changes on an enabled read, so it holds otherwise.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/program_memory_ctrl.sv
// Instruction store with an auto-incrementing burst loader and a 1-cycle
// handshaked fetch port; per-entry valid bits flag fetches of unloaded words.
module program_memory_ctrl
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              load_done,
    input  logic              rd_req,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_miss,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    pm_state_e         state_r;
    pm_state_e         state_s;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [CNT_W-1:0]  remain_r;
    logic [DEPTH-1:0]  valid_r;
    logic              load_done_r;
    logic              rd_valid_r;
    logic              rd_miss_r;
    logic              rd_seen_r;
    logic [DATA_W-1:0] ram_q_s;

    logic              start_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              last_s;

    // A start pulse is only honoured outside LOAD; mid-burst pulses are dropped.
    assign start_s  = load_start && (state_r != LOAD);
    assign wr_acc_s = wr_valid && (state_r == LOAD);
    assign rd_acc_s = rd_req && (state_r != LOAD);
    assign last_s   = (remain_r == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (wr_acc_s && last_s) begin
                    state_s = RUN;
                end else begin
                    state_s = LOAD;
                end
            end
            RUN: begin
                if (start_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Burst address and remaining-word counter; a zero length means a full sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_r <= {ADDR_W{1'b0}};
            remain_r  <= {CNT_W{1'b0}};
        end else if (start_s) begin
            wr_addr_r <= load_base;
            if (load_len == {ADDR_W{1'b0}}) begin
                remain_r <= CNT_W'(DEPTH);
            end else begin
                remain_r <= {1'b0, load_len};
            end
        end else if (wr_acc_s) begin
            wr_addr_r <= wr_addr_r + ADDR_W'(1);
            remain_r  <= remain_r - CNT_W'(1);
        end
    end

    // Per-entry loaded flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
        end else if (wr_acc_s) begin
            valid_r[wr_addr_r] <= 1'b1;
        end
    end

    // Completion pulse for the cycle after the final word is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_done_r <= 1'b0;
        end else begin
            load_done_r <= wr_acc_s && last_s;
        end
    end

    // Read response flags; rd_seen_r masks the unreset RAM output until the first read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_miss_r  <= 1'b0;
            rd_seen_r  <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                rd_miss_r <= ~valid_r[rd_addr];
                rd_seen_r <= 1'b1;
            end
        end
    end

    pm_ram_1r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_addr_r),
        .wdata (wr_data),
        .re    (rd_acc_s),
        .raddr (rd_addr),
        .rdata (ram_q_s)
    );

    assign wr_ready  = (state_r == LOAD);
    assign rd_ready  = (state_r != LOAD);
    assign busy      = (state_r == LOAD);
    assign load_done = load_done_r;
    assign rd_valid  = rd_valid_r;
    assign rd_miss   = rd_miss_r;
    assign rd_data   = rd_seen_r ? ram_q_s : {DATA_W{1'b0}};

endmodule

// File: tb/tb_program_memory_ctrl.sv
// Randomised self-checking bench for program_memory_ctrl against an
// array-based model of the store, its loaded flags and the burst rules.
module tb_program_memory_ctrl;

    localparam int DW    = 67;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic [AW-1:0] load_base;
    logic [AW-1:0] load_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          load_done;
    logic          rd_req;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_miss;
    logic          busy;

    logic [DW-1:0] mdl_mem   [DEPTH];
    bit            mdl_known [DEPTH];
    bit            mdl_vld   [DEPTH];
    logic [DW-1:0] pend_q[$];
    int            rq[$];
    int            n_pass = 0;
    int            n_total = 0;

    always #5 clk = ~clk;

    program_memory_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_base  (load_base),
        .load_len   (load_len),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .load_done  (load_done),
        .rd_req     (rd_req),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_miss    (rd_miss),
        .busy       (busy)
    );

    function automatic logic [DW-1:0] rand_word();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_start = 1'b0; load_base = '0; load_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0; rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_vld[i] = 1'b0; mdl_known[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({wr_ready, load_done, rd_valid, rd_miss, busy} !== 5'b0) begin
            $display("FAIL reset_flags: got %b want 00000", {wr_ready, load_done, rd_valid, rd_miss, busy});
        end else n_pass++;
        n_total++;
        if (rd_data !== {DW{1'b0}}) $display("FAIL reset_rd_data: got %h want 0", rd_data);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_read();
        wr_valid = 1'b1;
        wr_data  = rand_word();
        rd_req   = 1'b1;
        rd_addr  = AW'(3);
        n_total++;
        if (rd_ready !== 1'b1) $display("FAIL idle_rd_ready: got %b want 1", rd_ready);
        else n_pass++;
        tick();
        rd_req = 1'b0;
        wr_valid = 1'b0;
        n_total++;
        if ({rd_valid, rd_miss} !== 2'b11) $display("FAIL idle_read: got valid/miss %b want 11", {rd_valid, rd_miss});
        else n_pass++;
        n_total++;
        if ({wr_ready, busy} !== 2'b00) $display("FAIL idle_load_side: got wr_ready/busy %b want 00", {wr_ready, busy});
        else n_pass++;
        tick();
        n_total++;
        if ({rd_valid, rd_miss} !== 2'b01) $display("FAIL idle_hold: got valid/miss %b want 01", {rd_valid, rd_miss});
        else n_pass++;
    endtask

    task automatic start_load(input int base, input int len, input bit do_read, input int raddr);
        load_start = 1'b1;
        load_base  = AW'(base);
        load_len   = AW'(len);
        rd_req     = do_read;
        rd_addr    = AW'(raddr);
        if (do_read) begin
            n_total++;
            if (rd_ready !== 1'b1) $display("FAIL start_rd_ready: got %b want 1", rd_ready);
            else n_pass++;
        end
        tick();
        load_start = 1'b0;
        rd_req     = 1'b0;
        n_total++;
        if ({busy, wr_ready, rd_ready} !== 3'b110) $display("FAIL enter_load: got busy/wr_ready/rd_ready %b want 110", {busy, wr_ready, rd_ready});
        else n_pass++;
        if (do_read) begin
            n_total++;
            if ({rd_valid, rd_miss} !== {1'b1, ~mdl_vld[raddr]}) begin
                $display("FAIL start_read: got valid/miss %b want %b", {rd_valid, rd_miss}, {1'b1, ~mdl_vld[raddr]});
            end else n_pass++;
            if (mdl_known[raddr]) begin
                n_total++;
                if (rd_data !== mdl_mem[raddr]) $display("FAIL start_read_data: got %h want %h", rd_data, mdl_mem[raddr]);
                else n_pass++;
            end
        end
    endtask

    task automatic feed_words(input int base, input int len, input bit gap, input bit inject, input int stop_after);
        int  n;
        int  i;
        int  budget;
        int  a;
        bit  rd_was;
        n = (len == 0) ? DEPTH : len;
        i = 0;
        budget = 0;
        while (i < stop_after && budget < 400) begin
            budget++;
            wr_valid = gap ? ((budget % 2) == 1) : 1'b1;
            if (wr_valid && pend_q.size() > 0) wr_data = pend_q.pop_front();
            else wr_data = rand_word();
            load_start = inject && (budget == 2);
            load_base  = AW'($urandom_range(0, DEPTH - 1));
            load_len   = AW'($urandom_range(1, DEPTH - 1));
            rd_was     = (budget == 3);
            rd_req     = rd_was;
            rd_addr    = AW'($urandom_range(0, DEPTH - 1));
            n_total++;
            if (wr_ready !== 1'b1) $display("FAIL load_wr_ready: word %0d got %b want 1", i, wr_ready);
            else n_pass++;
            if (rd_was) begin
                n_total++;
                if (rd_ready !== 1'b0) $display("FAIL load_rd_ready: got %b want 0", rd_ready);
                else n_pass++;
            end
            tick();
            load_start = 1'b0;
            rd_req     = 1'b0;
            if (wr_valid) begin
                a = (base + i) % DEPTH;
                mdl_mem[a]   = wr_data;
                mdl_known[a] = 1'b1;
                mdl_vld[a]   = 1'b1;
                i++;
            end
            if (rd_was) begin
                n_total++;
                if (rd_valid !== 1'b0) $display("FAIL load_blocked_read: rd_valid got %b want 0", rd_valid);
                else n_pass++;
            end
            if (i == n) begin
                n_total++;
                if ({load_done, wr_ready, busy} !== 3'b100) $display("FAIL load_finish: got done/wr_ready/busy %b want 100", {load_done, wr_ready, busy});
                else n_pass++;
            end else begin
                n_total++;
                if (load_done !== 1'b0) $display("FAIL load_early_done: after %0d of %0d words got %b want 0", i, n, load_done);
                else n_pass++;
            end
        end
        wr_valid = 1'b0;
        if (i < stop_after) begin
            n_total++;
            $display("FAIL load_timeout: accepted %0d want %0d", i, stop_after);
        end
        if (stop_after == n) begin
            tick();
            n_total++;
            if ({load_done, busy, rd_ready} !== 3'b001) $display("FAIL done_single_pulse: got done/busy/rd_ready %b want 001", {load_done, busy, rd_ready});
            else n_pass++;
        end
    endtask

    task automatic read_queue();
        int a;
        int last_a;
        last_a = -1;
        while (rq.size() > 0) begin
            a = rq.pop_front();
            rd_req  = 1'b1;
            rd_addr = AW'(a);
            n_total++;
            if (rd_ready !== 1'b1) $display("FAIL read_rd_ready: addr %0d got %b want 1", a, rd_ready);
            else n_pass++;
            tick();
            n_total++;
            if ({rd_valid, rd_miss} !== {1'b1, ~mdl_vld[a]}) begin
                $display("FAIL read_flags: addr %0d got valid/miss %b want %b", a, {rd_valid, rd_miss}, {1'b1, ~mdl_vld[a]});
            end else n_pass++;
            if (mdl_known[a]) begin
                n_total++;
                if (rd_data !== mdl_mem[a]) $display("FAIL read_data: addr %0d got %h want %h", a, rd_data, mdl_mem[a]);
                else n_pass++;
            end
            last_a = a;
        end
        rd_req = 1'b0;
        tick();
        n_total++;
        if (rd_valid !== 1'b0) $display("FAIL read_idle_valid: got %b want 0", rd_valid);
        else n_pass++;
        if (last_a >= 0 && mdl_known[last_a]) begin
            n_total++;
            if (rd_data !== mdl_mem[last_a]) $display("FAIL read_hold: got %h want %h", rd_data, mdl_mem[last_a]);
            else n_pass++;
        end
    endtask

    task automatic test_basic_load();
        pend_q = '{67'h11, 67'h22, 67'h33};
        start_load(4, 3, 1'b0, 0);
        feed_words(4, 3, 1'b0, 1'b0, 3);
        rq = '{4, 5, 6};
        read_queue();
    endtask

    task automatic test_wrap();
        pend_q = '{67'hA, 67'hB, 67'hC, 67'hD};
        start_load(30, 4, 1'b0, 0);
        feed_words(30, 4, 1'b0, 1'b0, 4);
        rq = '{30, 31, 0, 1};
        read_queue();
    endtask

    task automatic test_full_gap();
        start_load(7, 0, 1'b0, 0);
        feed_words(7, 0, 1'b1, 1'b0, DEPTH);
        for (int k = 0; k < 8; k++) rq.push_back($urandom_range(0, DEPTH - 1));
        read_queue();
    endtask

    task automatic test_load_collisions();
        start_load(12, 5, 1'b1, 4);
        feed_words(12, 5, 1'b0, 1'b1, 5);
        rq = '{12, 16, 4};
        read_queue();
    endtask

    task automatic test_random();
        int b;
        int l;
        for (int r = 0; r < 6; r++) begin
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 9);
            start_load(b, l, r[0], $urandom_range(0, DEPTH - 1));
            feed_words(b, l, r[1], 1'b0, (l == 0) ? DEPTH : l);
            for (int k = 0; k < 5; k++) rq.push_back($urandom_range(0, DEPTH - 1));
            read_queue();
        end
    endtask

    task automatic test_reset_mid_load();
        start_load(20, 5, 1'b0, 0);
        feed_words(20, 5, 1'b0, 1'b0, 2);
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < DEPTH; i++) mdl_vld[i] = 1'b0;
        n_total++;
        if ({wr_ready, load_done, rd_valid, rd_miss, busy, rd_ready} !== 6'b000001) begin
            $display("FAIL midload_reset: got %b want 000001", {wr_ready, load_done, rd_valid, rd_miss, busy, rd_ready});
        end else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++;
        if ({load_done, busy} !== 2'b00) $display("FAIL midload_no_done: got done/busy %b want 00", {load_done, busy});
        else n_pass++;
        rq = '{20, 21};
        read_queue();
    endtask

    initial begin
        test_reset();
        test_idle_read();
        test_basic_load();
        test_wrap();
        test_full_gap();
        test_load_collisions();
        test_random();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
